// File: rtl/vote_round_ctrl.sv
// vote_round_ctrl: one timed voting round per start. Latches each judge's
// first press, presents the latched votes to the external majority voter,
// captures its verdict and keeps saturating pass/fail tallies.
module vote_round_ctrl #(
    parameter int WINDOW = 16,  // collect length in cycles (>=2)
    parameter int HOLD   = 4,   // result hold length in cycles (>=1)
    parameter int CW     = 8    // tally width
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          btn_a,
    input  logic          btn_b,
    input  logic          btn_c,
    input  logic          maj,
    output logic          va,
    output logic          vb,
    output logic          vc,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [CW-1:0] pass_cnt,
    output logic [CW-1:0] fail_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_EVAL,
        S_RESULT
    } state_t;

    // One timer serves both the collect window and the result hold.
    localparam int TMAX = (WINDOW > HOLD) ? WINDOW : HOLD;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] WIN_LAST  = TW'(WINDOW - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    state_t        state, state_nxt;
    logic [TW-1:0] timer;
    logic          all_in;

    // Early exit looks at this cycle's presses too, so a vote arriving on the
    // same edge as the third latch still ends the window immediately.
    assign all_in = (va | btn_a) & (vb | btn_b) & (vc | btn_c);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_COLLECT;
            S_COLLECT: if (timer == WIN_LAST || all_in) state_nxt = S_EVAL;
            S_EVAL:    state_nxt = S_RESULT;
            S_RESULT:  if (timer == HOLD_LAST) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Registered datapath: votes, timer, verdict, tallies and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            va       <= 1'b0;
            vb       <= 1'b0;
            vc       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            timer    <= '0;
        end else begin
            done <= 1'b0;
            busy <= (state_nxt != S_IDLE);
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (start) begin
                        va <= 1'b0;
                        vb <= 1'b0;
                        vc <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    // Sticky: a release never clears a latched vote.
                    va    <= va | btn_a;
                    vb    <= vb | btn_b;
                    vc    <= vc | btn_c;
                    timer <= timer + TW'(1);
                end
                S_EVAL: begin
                    pass    <= maj;
                    timeout <= ~(va & vb & vc);
                    done    <= 1'b1;
                    timer   <= '0;
                    if (maj) begin
                        if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CW'(1);
                    end else begin
                        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CW'(1);
                    end
                end
                S_RESULT: begin
                    timer <= timer + TW'(1);
                end
                default: timer <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_vote_round_ctrl.sv
// tb_vote_round_ctrl: scoreboard bench. Each round pushes its expected verdict
// when driven; a monitor pops and compares whenever the DUT pulses done.
module tb_vote_round_ctrl;

    localparam int WINDOW = 16;
    localparam int HOLD   = 4;
    localparam int CW     = 2;
    localparam int CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, start, btn_a, btn_b, btn_c, maj;
    logic          va, vb, vc, busy, done, pass, timeout;
    logic [CW-1:0] pass_cnt, fail_cnt;

    typedef struct {
        logic       pass;
        logic       timeout;
        logic [2:0] votes;
        int         pcnt;
        int         fcnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t e_mon;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   m_pcnt = 0;
    int   m_fcnt = 0;

    vote_round_ctrl #(.WINDOW(WINDOW), .HOLD(HOLD), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .btn_a(btn_a), .btn_b(btn_b), .btn_c(btn_c), .maj(maj),
        .va(va), .vb(vb), .vc(vc), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    // match3 stand-in: combinational 2-of-3 majority on the latched votes.
    assign maj = (va & vb) | (vb & vc) | (va & vc);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Verdict monitor: every done pulse must match the oldest pending round.
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                e_mon = sb_q.pop_front();
                chk("pass",     pass,           e_mon.pass);
                chk("timeout",  timeout,        e_mon.timeout);
                chk("votes",    {va, vb, vc},   e_mon.votes);
                chk("pass_cnt", pass_cnt,       e_mon.pcnt);
                chk("fail_cnt", fail_cnt,       e_mon.fcnt);
            end
        end
    end

    // mask = {a,b,c}; pressed for one cycle in COLLECT cycle pc, or together
    // with start when with_start is set; drop pokes start during RESULT.
    task automatic round(input logic [2:0] mask, input int pc, input bit with_start, input bit drop);
        exp_t       e;
        logic [2:0] v;
        int         len, n, ones;
        v    = with_start ? 3'b000 : mask;
        len  = (!with_start && mask == 3'b111) ? pc + 1 : WINDOW;
        ones = int'(v[0]) + int'(v[1]) + int'(v[2]);
        e.pass    = (ones >= 2);
        e.timeout = (v != 3'b111);
        e.votes   = v;
        if (e.pass) begin if (m_pcnt < CMAX) m_pcnt++; end
        else        begin if (m_fcnt < CMAX) m_fcnt++; end
        e.pcnt = m_pcnt;
        e.fcnt = m_fcnt;
        sb_q.push_back(e);

        start = 1'b1;
        if (with_start) {btn_a, btn_b, btn_c} = mask;
        tick();
        start = 1'b0;
        {btn_a, btn_b, btn_c} = 3'b000;
        chk("busy_after_start", busy, 1);
        chk("votes_cleared", {va, vb, vc}, 0);
        n = 0;
        if (!with_start) begin
            repeat (pc) tick();
            {btn_a, btn_b, btn_c} = mask;
            tick();
            {btn_a, btn_b, btn_c} = 3'b000;
            n = pc + 1;
        end
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk("done_latency", n, len + 1);
        for (int i = 1; i < HOLD; i++) begin
            if (drop && i == 1) start = 1'b1;
            tick();
            start = 1'b0;
            chk("hold_busy", busy, 1);
            chk("hold_done", done, 0);
            chk("hold_votes", {va, vb, vc}, v);
        end
        tick();
        chk("idle_busy", busy, 0);
        tick();
        chk("idle_stays", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1;
        btn_a = 1'b0; btn_b = 1'b0; btn_c = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_outs", {va, vb, vc, done, pass, timeout}, 0);
        chk("rst_cnts", {pass_cnt, fail_cnt}, 0);
        rst = 1'b0; start = 1'b0;
        tick();
        chk("idle_after_rst", busy, 0);

        round(3'b110, 3, 1'b0, 1'b0);          // A,B only: timeout pass
        round(3'b111, 2, 1'b0, 1'b0);          // all three: early exit
        round(3'b001, 5, 1'b0, 1'b0);          // C only: fail
        round(3'b011, WINDOW - 1, 1'b0, 1'b0); // press on final cycle counts
        round(3'b111, 0, 1'b1, 1'b0);          // presses with start ignored
        round(3'b101, 7, 1'b0, 1'b1);          // pass tally saturates
        round(3'b111, 0, 1'b0, 1'b1);          // immediate early exit

        // Reset in the middle of collect abandons the round.
        start = 1'b1; tick(); start = 1'b0;
        tick();
        btn_a = 1'b1; tick(); btn_a = 1'b0;
        tick();
        chk("mid_va", va, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        m_pcnt = 0; m_fcnt = 0;
        chk("mid_rst_va", va, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cnts", {pass_cnt, fail_cnt}, 0);
        repeat (WINDOW + 4) tick();
        chk("mid_rst_no_done", busy, 0);

        round(3'b010, 1, 1'b0, 1'b0);          // fresh tallies after reset

        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
